// File: rtl/stage_if_queue_pkg.sv
// Shared fetch-stage definitions: bus widths, PC step and fetch FSM encodings.
package stage_if_queue_pkg;

  localparam int unsigned MEM_ADDR_BUS = 32;
  localparam int unsigned INST_BUS     = 32;
  localparam int unsigned IF_PC_STEP   = 4;

  // Fetch FSM encodings
  localparam logic [1:0] IF_IDLE    = 2'd0;
  localparam logic [1:0] IF_WAIT    = 2'd1;
  localparam logic [1:0] IF_DISCARD = 2'd2;

endpackage

// File: rtl/stage_if_queue_if.sv
// Fetch-stage bus bundle: EX redirect, memory arbiter request/response, ID handshake.
interface stage_if_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);

  logic              br;
  logic [ADDR_W-1:0] br_addr;
  logic              ram_busy;
  logic              ram_read;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ready;
  logic [INST_W-1:0] ram_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_o;
  logic              stall_if;

  // Fetch stage side
  modport master (
    input  br, br_addr, ram_busy, ram_ready, ram_data, out_ready,
    output ram_read, ram_addr, out_valid, pc_o, inst_o, stall_if
  );

  // Environment side (EX, arbiter, ID)
  modport slave (
    output br, br_addr, ram_busy, ram_ready, ram_data, out_ready,
    input  ram_read, ram_addr, out_valid, pc_o, inst_o, stall_if
  );

endinterface

// File: rtl/stage_if_queue_fifo.sv
// Synchronous circular FIFO for {pc, inst} pairs; flush beats push and pop.
module if_inst_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Status and head read-out; head reads as zero when empty
  always_comb begin
    full    = (count == (PTR_W+1)'(DEPTH));
    empty   = (count == '0);
    push_ok = push && !full && !flush;
    pop_ok  = pop && !empty && !flush;
    dout    = empty ? '0 : mem[rd_ptr];
  end

  // Pointer and occupancy tracking; pointers wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/stage_if_queue.sv
// Instruction fetch stage with prefetch queue: one outstanding read, slot
// reserved before issue, branch flushes the queue and kills any in-flight read.
module stage_if_queue
  import stage_if_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = MEM_ADDR_BUS,
  parameter int unsigned       INST_W   = INST_BUS,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = IF_PC_STEP
) (
  input  logic             clk,
  input  logic             reset_n,
  stage_if_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [1:0]              state;
  logic [ADDR_W-1:0]       fetch_pc;
  logic                    ram_read_q;
  logic [ADDR_W-1:0]       ram_addr_q;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [PTR_W:0]          fifo_count;
  logic [ADDR_W+INST_W-1:0] fifo_dout;
  logic [PTR_W+1:0]        used;
  logic                    slot_free;

  // Queue control and slot reservation: an outstanding read already owns a slot
  always_comb begin
    used      = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, (state != IF_IDLE)};
    slot_free = (used < (PTR_W+2)'(DEPTH));
    fifo_push = (state == IF_WAIT) && bus.ram_ready && !bus.br && !fifo_full;
    fifo_pop  = !fifo_empty && bus.out_ready && !bus.br;
  end

  if_inst_fifo #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (bus.br),
    .din     ({ram_addr_q, bus.ram_data}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Fetch FSM, PC register and request outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IF_IDLE;
      fetch_pc   <= RESET_PC;
      ram_read_q <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      case (state)
        IF_IDLE: begin
          if (bus.br) begin
            fetch_pc <= bus.br_addr;
          end else if (slot_free && !bus.ram_busy) begin
            ram_read_q <= 1'b1;
            ram_addr_q <= fetch_pc;
            state      <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          // A response coinciding with br completes the read but is not pushed
          if (bus.ram_ready) begin
            ram_read_q <= 1'b0;
            state      <= IF_IDLE;
          end else if (bus.br) begin
            state      <= IF_DISCARD;
          end
          if (bus.br)
            fetch_pc <= bus.br_addr;
          else if (bus.ram_ready)
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        end
        IF_DISCARD: begin
          if (bus.br) fetch_pc <= bus.br_addr;
          if (bus.ram_ready) begin
            ram_read_q <= 1'b0;
            state      <= IF_IDLE;
          end
        end
        default: begin
          state      <= IF_IDLE;
          ram_read_q <= 1'b0;
        end
      endcase
    end
  end

  // Output drive
  always_comb begin
    bus.ram_read  = ram_read_q;
    bus.ram_addr  = ram_addr_q;
    bus.out_valid = !fifo_empty;
    bus.stall_if  = fifo_empty;
    bus.pc_o      = fifo_dout[ADDR_W+INST_W-1:INST_W];
    bus.inst_o    = fifo_dout[INST_W-1:0];
  end

`ifndef SYNTHESIS
  // A response with no outstanding request is an arbiter protocol error
  assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.ram_ready && state == IF_IDLE))
    else $error("stage_if_queue: ram_ready with no outstanding request");
`endif

endmodule

// File: tb/tb_stage_if_queue.sv
// Directed bench for stage_if_queue with a memory model and an {pc,inst} scoreboard.
module tb_stage_if_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stage_if_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  stage_if_queue #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [ADDR_W+INST_W-1:0] sb[$];
  logic [ADDR_W-1:0]        pop_pcs[$];
  logic [ADDR_W-1:0]        exp_fetch;
  logic                     stale;
  logic                     prev_read;
  logic                     force_ready;
  int unsigned              age;
  int unsigned              mem_lat;
  int                       pops;
  int                       waited;

  function automatic logic [INST_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    pop_pcs.delete();
    exp_fetch       = 32'h0;
    stale           = 1'b0;
    prev_read       = 1'b0;
    age             = 0;
    pops            = 0;
    bus.ram_ready   = 1'b0;
  endtask

  // One clock: ID-side checks and memory response decided mid-cycle, then the edge
  task automatic cycle();
    logic [ADDR_W+INST_W-1:0] e;
    @(negedge clk);
    check("out_valid", bus.out_valid, sb.size() != 0);
    check("stall_if", bus.stall_if, sb.size() == 0);
    if (bus.out_valid && bus.out_ready && !bus.br) begin
      if (sb.size() == 0) begin
        check("pop_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pc_o", bus.pc_o, e[ADDR_W+INST_W-1:INST_W]);
        check("inst_o", bus.inst_o, e[INST_W-1:0]);
        pop_pcs.push_back(bus.pc_o);
        pops++;
      end
    end
    if (bus.br) sb.delete();
    if (bus.ram_read && !prev_read) check("req_addr", bus.ram_addr, exp_fetch);
    prev_read = bus.ram_read;
    if (bus.ram_ready) begin
      bus.ram_ready = 1'b0;
    end else if (bus.ram_read) begin
      if (force_ready || age >= mem_lat) begin
        bus.ram_ready = 1'b1;
        bus.ram_data  = word_of(bus.ram_addr);
        age = 0;
        if (!stale && !bus.br) begin
          sb.push_back({bus.ram_addr, bus.ram_data});
          exp_fetch = exp_fetch + 32'd4;
        end
        stale = 1'b0;
      end else begin
        age++;
      end
    end
    if (bus.br && bus.ram_read && !bus.ram_ready) stale = 1'b1;
    if (bus.br) exp_fetch = bus.br_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_read", bus.ram_read, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pc_o", bus.pc_o, 0);
    check("rst_inst_o", bus.inst_o, 0);
    check("rst_stall_if", bus.stall_if, 1);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.br        = 1'b0;
    bus.br_addr   = '0;
    bus.ram_busy  = 1'b0;
    bus.ram_ready = 1'b0;
    bus.ram_data  = '0;
    bus.out_ready = 1'b0;
    mem_lat       = 1;
    force_ready   = 1'b0;

    // Streaming fetch with ID always ready
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 80 && pops < 4; i++) cycle();
    check("t1_pops", pops >= 4, 1);
    if (pop_pcs.size() >= 2) begin
      check("t1_first_pc", pop_pcs[0], 32'h0);
      check("t1_second_pc", pop_pcs[1], 32'h4);
    end

    // Fill to DEPTH, then one pop reopens fetch at 0x10
    do_reset();
    bus.out_ready = 1'b0;
    repeat (30) cycle();
    check("t2_sb_full", sb.size(), DEPTH);
    check("t2_count", dut.u_fifo.count, DEPTH);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t2_no_issue_full", bus.ram_read, 0);
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    waited = 0;
    for (int i = 0; i < 4 && !bus.ram_read; i++) begin
      cycle();
      waited++;
    end
    check("t2_issue_after_pop", bus.ram_read, 1);
    check("t2_issue_delay", waited, 1);
    check("t2_issue_addr", bus.ram_addr, 32'h10);

    // Branch while waiting on 0x8
    do_reset();
    bus.out_ready = 1'b0;
    mem_lat = 3;
    for (int i = 0; i < 60 && !(bus.ram_read && bus.ram_addr == 32'h8); i++) cycle();
    check("t3_wait_on_8", bus.ram_read && bus.ram_addr == 32'h8, 1);
    bus.br = 1'b1;
    bus.br_addr = 32'h100;
    cycle();
    bus.br = 1'b0;
    check("t3_flush_valid", bus.out_valid, 0);
    check("t3_flush_count", dut.u_fifo.count, 0);
    bus.out_ready = 1'b1;
    mem_lat = 1;
    for (int i = 0; i < 60 && pops < 1; i++) cycle();
    check("t3_pops", pops >= 1, 1);
    if (pop_pcs.size() >= 1) check("t3_first_pc", pop_pcs[0], 32'h100);

    // Branch and response in the same cycle, ID ready
    do_reset();
    bus.out_ready = 1'b0;
    mem_lat = 1;
    for (int i = 0; i < 60 && sb.size() < 2; i++) cycle();
    check("t4_prefill", sb.size(), 2);
    mem_lat = 50;
    for (int i = 0; i < 10 && !bus.ram_read; i++) cycle();
    check("t4_in_wait", bus.ram_read, 1);
    bus.out_ready = 1'b1;
    bus.br = 1'b1;
    bus.br_addr = 32'h200;
    force_ready = 1'b1;
    cycle();
    bus.br = 1'b0;
    force_ready = 1'b0;
    check("t4_count", dut.u_fifo.count, 0);
    check("t4_valid", bus.out_valid, 0);
    check("t4_read_dropped", bus.ram_read, 0);
    mem_lat = 1;
    for (int i = 0; i < 60 && pops < 1; i++) cycle();
    check("t4_pops", pops >= 1, 1);
    if (pop_pcs.size() >= 1) check("t4_first_pc", pop_pcs[0], 32'h200);

    // Arbiter busy from idle
    bus.ram_busy = 1'b1;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5_busy_no_read", bus.ram_read, 0);
    end
    bus.ram_busy = 1'b0;
    cycle();
    check("t5_read_rises", bus.ram_read, 1);
    check("t5_read_addr", bus.ram_addr, 32'h0);

    // Reset mid-request, stray response during reset
    do_reset();
    bus.out_ready = 1'b0;
    mem_lat = 1;
    for (int i = 0; i < 40 && sb.size() < 1; i++) cycle();
    mem_lat = 4;
    for (int i = 0; i < 10 && !bus.ram_read; i++) cycle();
    check("t6_in_wait", bus.ram_read, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_read", bus.ram_read, 0);
    check("t6_async_valid", bus.out_valid, 0);
    clear_model();
    bus.ram_ready = 1'b1;
    bus.ram_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.ram_ready = 1'b0;
    reset_n = 1'b1;
    cycle();
    check("t6_no_stray_push", dut.u_fifo.count, 0);
    bus.out_ready = 1'b1;
    mem_lat = 1;
    for (int i = 0; i < 40 && pops < 1; i++) cycle();
    check("t6_pops", pops >= 1, 1);
    if (pop_pcs.size() >= 1) check("t6_first_pc", pop_pcs[0], 32'h0);

    // PC wraps at the top of the address space
    do_reset();
    bus.out_ready = 1'b1;
    mem_lat = 1;
    bus.br = 1'b1;
    bus.br_addr = 32'hFFFF_FFF8;
    cycle();
    bus.br = 1'b0;
    for (int i = 0; i < 60 && pops < 3; i++) cycle();
    check("t7_pops", pops >= 3, 1);
    if (pop_pcs.size() >= 3) begin
      check("t7_pc0", pop_pcs[0], 32'hFFFF_FFF8);
      check("t7_pc1", pop_pcs[1], 32'hFFFF_FFFC);
      check("t7_pc2_wrap", pop_pcs[2], 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
